bulk_ep_in_packetizer: RTL and testbench

Device-to-host bulk IN endpoint packetizer in the USB clock domain; the transmit-side counterpart of the bulk OUT endpoint. Accepts a byte-wide AXI-Stream from the user side (after any clock-domain FIFO), cuts it into packets of at most `MAX_PACKET` bytes, and holds each packet in a local buffer until the host ACKs it. Signals packet availability to the USB protocol core, replays the buffered packet on retry, and optionally appends a zero-length packet (ZLP) to frames that end exactly on a packet boundary.

---
 rtl/bulk_ep_in_packetizer.sv | 175 +++++++++++++++++
 tb/tb_bulk_ep_in_packetizer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_ep_in_packetizer.sv
// Bulk IN endpoint packetizer: cuts a byte stream into packets, buffers each until ACKed.
// Optional zero-length packet support is compiled in with `define BULK_EP_IN_ZLP_EN.
module bulk_ep_in_packetizer #(
  parameter int unsigned MAX_PACKET = 512,
  parameter int unsigned ABITS      = 9
) (
  input  logic       bulk_ep_in_clock,
  input  logic       reset_n,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  input  logic       s_tlast_i,
  input  logic [7:0] s_tdata_i,
  input  logic       bulk_ep_in_xfer_i,
  output logic       bulk_ep_in_has_data_o,
  input  logic       bulk_ep_in_ack_i,
  output logic       bulk_ep_in_tvalid_o,
  input  logic       bulk_ep_in_tready_i,
  output logic       bulk_ep_in_tlast_o,
  output logic       bulk_ep_in_tkeep_o,
  output logic [7:0] bulk_ep_in_tdata_o,
  output logic       status_busy_o
);

  localparam int unsigned    Depth  = 1 << ABITS;
  localparam logic [ABITS:0] MaxPkt = MAX_PACKET[ABITS:0];
  localparam logic [ABITS:0] One    = {{ABITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StFill, StReady, StSend, StWaitAck} state_e;

  state_e         r_state, w_state_next;
  logic [ABITS:0] r_count, r_len, r_rd_ptr;
  logic           r_rd_done;
  logic           r_p1_valid, r_p1_last, r_p1_keep;
  logic [7:0]     r_mem_q;
  logic [7:0]     r_mem [Depth];
  logic           r_out_valid, r_out_last, r_out_keep;
  logic [7:0]     r_out_data;
  logic           r_in_en;

  logic           w_in_hs, w_commit, w_start, w_adv, w_last_hs, w_ack, w_zlp;
  logic           w_rd_en;
  logic [ABITS:0] w_count_inc, w_rd_ptr_inc;
  logic [ABITS-1:0] w_rd_addr;

  assign s_tready_o            = r_in_en && (r_state == StFill);
  assign bulk_ep_in_has_data_o = (r_state != StFill);
  assign status_busy_o         = (r_state != StFill);
  assign bulk_ep_in_tvalid_o   = r_out_valid;
  assign bulk_ep_in_tlast_o    = r_out_last;
  assign bulk_ep_in_tkeep_o    = r_out_keep;
  assign bulk_ep_in_tdata_o    = r_out_data;

  assign w_in_hs      = s_tready_o && s_tvalid_i;
  assign w_count_inc  = r_count + One;
  assign w_commit     = w_in_hs && ((w_count_inc == MaxPkt) || s_tlast_i);
  assign w_ack        = (r_state == StWaitAck) && bulk_ep_in_ack_i;
  // A retry in WAIT_ACK loses to a simultaneous ACK.
  assign w_start      = bulk_ep_in_xfer_i && ((r_state == StReady) ||
                        ((r_state == StWaitAck) && !bulk_ep_in_ack_i));
  assign w_adv        = !r_out_valid || bulk_ep_in_tready_i;
  assign w_last_hs    = r_out_valid && bulk_ep_in_tready_i && r_out_last;
  assign w_rd_ptr_inc = r_rd_ptr + One;
  assign w_rd_en      = w_start || ((r_state == StSend) && w_adv && !r_rd_done);
  assign w_rd_addr    = w_start ? '0 : r_rd_ptr[ABITS-1:0];

`ifdef BULK_EP_IN_ZLP_EN
  logic r_zlp;

  always_ff @(posedge bulk_ep_in_clock) begin
    if (!reset_n) begin
      r_zlp <= 1'b0;
    end else if (w_commit && (w_count_inc == MaxPkt) && s_tlast_i) begin
      r_zlp <= 1'b1;
    end else if (w_ack) begin
      r_zlp <= 1'b0;
    end
  end

  assign w_zlp = r_zlp;
`else
  assign w_zlp = 1'b0;
`endif

  always_ff @(posedge bulk_ep_in_clock) begin
    if (!reset_n) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFill:    if (w_commit) w_state_next = StReady;
      StReady:   if (bulk_ep_in_xfer_i) w_state_next = StSend;
      StSend:    if (w_last_hs) w_state_next = StSend == StSend ? StWaitAck : StSend;
      StWaitAck: begin
        if (bulk_ep_in_ack_i) begin
          w_state_next = w_zlp ? StReady : StFill;
        end else if (bulk_ep_in_xfer_i) begin
          w_state_next = StSend;
        end
      end
      default:   w_state_next = StFill;
    endcase
  end

  // Packet RAM: no reset, contents are only meaningful up to r_len.
  always_ff @(posedge bulk_ep_in_clock) begin
    if (w_in_hs) begin
      r_mem[r_count[ABITS-1:0]] <= s_tdata_i;
    end
    if (w_rd_en) begin
      r_mem_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge bulk_ep_in_clock) begin
    if (!reset_n) begin
      r_in_en     <= 1'b0;
      r_count     <= '0;
      r_len       <= '0;
      r_rd_ptr    <= '0;
      r_rd_done   <= 1'b0;
      r_p1_valid  <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p1_keep   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_en <= 1'b1;
      if (w_in_hs) begin
        r_count <= w_count_inc;
      end
      if (w_commit) begin
        r_len <= w_count_inc;
      end
      if (w_ack) begin
        r_count <= '0;
        if (w_zlp) begin
          r_len <= '0;
        end
      end

      // Stage 1 is the RAM output register; the first read issues with the xfer itself.
      if (w_start) begin
        r_p1_valid <= 1'b1;
        r_p1_last  <= (r_len <= One);
        r_p1_keep  <= (r_len != '0);
        r_rd_ptr   <= One;
        r_rd_done  <= (r_len <= One);
      end else if ((r_state == StSend) && w_adv) begin
        r_p1_valid <= !r_rd_done;
        if (!r_rd_done) begin
          r_rd_ptr  <= w_rd_ptr_inc;
          r_p1_last <= (w_rd_ptr_inc == r_len);
          r_p1_keep <= 1'b1;
          r_rd_done <= (w_rd_ptr_inc == r_len);
        end
      end

      // Output stage holds everything while the core stalls.
      if ((r_state == StSend) && w_adv) begin
        r_out_valid <= r_p1_valid;
        r_out_last  <= r_p1_valid && r_p1_last;
        r_out_keep  <= r_p1_valid && r_p1_keep;
        r_out_data  <= (r_p1_valid && r_p1_keep) ? r_mem_q : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_bulk_ep_in_packetizer.sv
// Self-checking bench for bulk_ep_in_packetizer: frame-level packet model with random
// input gaps and random core backpressure.
module tb_bulk_ep_in_packetizer;

  localparam int unsigned MaxPacket = 512;
  localparam int unsigned ABits     = 9;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] s_tdata;
  logic       xfer, has_data, ack;
  logic       m_tvalid, m_tready, m_tlast, m_tkeep;
  logic [7:0] m_tdata;
  logic       busy;

  always #5 clk = ~clk;

  bulk_ep_in_packetizer #(
    .MAX_PACKET(MaxPacket),
    .ABITS     (ABits)
  ) u_dut (
    .bulk_ep_in_clock     (clk),
    .reset_n              (reset_n),
    .s_tvalid_i           (s_tvalid),
    .s_tready_o           (s_tready),
    .s_tlast_i            (s_tlast),
    .s_tdata_i            (s_tdata),
    .bulk_ep_in_xfer_i    (xfer),
    .bulk_ep_in_has_data_o(has_data),
    .bulk_ep_in_ack_i     (ack),
    .bulk_ep_in_tvalid_o  (m_tvalid),
    .bulk_ep_in_tready_i  (m_tready),
    .bulk_ep_in_tlast_o   (m_tlast),
    .bulk_ep_in_tkeep_o   (m_tkeep),
    .bulk_ep_in_tdata_o   (m_tdata),
    .status_busy_o        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] frame_q[$];
  int         exp_pkts[$];
  logic [7:0] rx_data[$];
  logic       rx_keep[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame splits into MaxPacket chunks, plus an empty packet when enabled.
  task automatic gen_frame(input int len, input bit rnd);
    frame_q.delete();
    exp_pkts.delete();
    for (int i = 0; i < len; i++) begin
      frame_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
    end
    for (int rem = len; rem > 0; rem -= MaxPacket) begin
      exp_pkts.push_back(rem > MaxPacket ? MaxPacket : rem);
    end
`ifdef BULK_EP_IN_ZLP_EN
    if (len % MaxPacket == 0) exp_pkts.push_back(0);
`endif
  endtask

  task automatic push_byte(input logic [7:0] d, input bit last, output bit ok);
    bit hs;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    ok = 1'b0;
    for (int w = 0; w < 20000; w++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps);
    bit ok;
    @(posedge clk);
    #1;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      push_byte(frame_q[i], i == frame_q.size() - 1, ok);
      if (!ok) begin
        check_eq("drv_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic wait_has_data(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 20000; w++) begin
      @(negedge clk);
      if (has_data) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("has_data_timeout", 0, 1);
  endtask

  // Issue one IN token and collect beats; abort_at > 0 stops after that many beats.
  task automatic collect(input bit rnd, input int abort_at, output int cyc, output bit done);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    rx_data.delete();
    rx_keep.delete();
    done = 1'b0;
    cyc  = 0;
    @(posedge clk);
    #1 xfer = 1'b1;
    @(posedge clk);
    #1 xfer = 1'b0;
    @(negedge clk);
    check_eq("lat_early", m_tvalid, 0);
    while (!done && cyc < 6000) begin
      if (abort_at > 0 && rx_data.size() == abort_at) break;
      @(posedge clk);
      #1 m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("lat_rise", m_tvalid, 1);
      if (m_tvalid) begin
        if (prev_stall) check_eq("hold_data", m_tdata, prev_d);
        if (m_tready) begin
          rx_data.push_back(m_tdata);
          rx_keep.push_back(m_tkeep);
          if (m_tlast) done = 1'b1;
        end
        prev_stall = !m_tready;
        prev_d     = m_tdata;
      end else begin
        if (prev_stall) check_eq("valid_dropped", 0, 1);
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic run_packet(input int plen, input int base, input bit rnd);
    int cyc;
    bit done;
    collect(rnd, 0, cyc, done);
    if (!done) begin
      check_eq("rx_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    #1 m_tready = 1'b0;
    @(negedge clk);
    check_eq("tvalid_drop", m_tvalid, 0);
    check_eq("tlast_drop", m_tlast, 0);
    if (plen == 0) begin
      check_eq("zlp_beats", rx_data.size(), 1);
      check_eq("zlp_keep", rx_keep[0], 0);
    end else begin
      check_eq("pkt_len", rx_data.size(), plen);
      if (!rnd) check_eq("no_bubble", cyc, plen);
      for (int i = 0; i < rx_data.size() && i < plen; i++) begin
        check_eq("pkt_byte", rx_data[i], frame_q[base + i]);
        check_eq("pkt_keep", rx_keep[i], 1);
      end
    end
  endtask

  task automatic host_frame(input bit rnd, input bit retry_first);
    int rd_idx = 0;
    bit ok;
    for (int p = 0; p < exp_pkts.size(); p++) begin
      wait_has_data(ok);
      if (!ok) return;
      run_packet(exp_pkts[p], rd_idx, rnd);
      if (p == 0 && retry_first) begin
        check_eq("retry_has_data", has_data, 1);
        run_packet(exp_pkts[p], rd_idx, rnd);
      end
      rd_idx += exp_pkts[p];
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      @(negedge clk);
      if (p + 1 < exp_pkts.size() && exp_pkts[p + 1] == 0) begin
        check_eq("ack_zlp_has_data", has_data, 1);
      end else begin
        check_eq("ack_tready", s_tready, 1);
        check_eq("ack_has_data", has_data, 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tready"}, s_tready, 0);
    check_eq({tag, "_has_data"}, has_data, 0);
    check_eq({tag, "_tvalid"}, m_tvalid, 0);
    check_eq({tag, "_tlast"}, m_tlast, 0);
    check_eq({tag, "_tkeep"}, m_tkeep, 0);
    check_eq({tag, "_tdata"}, m_tdata, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_tready", s_tready, 1);
    check_eq("rel_busy", busy, 0);
  endtask

  task automatic full_frame(input int len, input bit rnd_data, input bit gaps, input bit rnd_rdy,
                            input bit retry);
    gen_frame(len, rnd_data);
    fork
      drive_frame(gaps);
      host_frame(rnd_rdy, retry);
    join
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  done;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    xfer     = 1'b0;
    ack      = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    release_reset();

    // 10-byte frame 0x00..0x09.
    gen_frame(10, 1'b0);
    drive_frame(1'b0);
    @(negedge clk);
    check_eq("commit_has_data", has_data, 1);
    check_eq("commit_tready", s_tready, 0);
    check_eq("commit_busy", busy, 1);
    host_frame(1'b0, 1'b0);

    // 1200 bytes -> 512, 512, 176 with the input stalled between ACKs.
    full_frame(1200, 1'b1, 1'b1, 1'b0, 1'b0);

    // Retry replays the identical packet.
    full_frame(512, 1'b1, 1'b0, 1'b0, 1'b1);

    // Exact 512-byte frame: ZLP only when compiled in.
    full_frame(512, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("idle_has_data", has_data, 0);

    // Backpressure on a 64-byte packet.
    full_frame(64, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int f = 0; f < 4; f++) begin
      full_frame($urandom_range(1, 1100), 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    end
    full_frame(1024, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-SEND after 100 of 512 bytes.
    gen_frame(512, 1'b1);
    drive_frame(1'b0);
    collect(1'b0, 100, cyc, done);
    check_eq("abort_count", rx_data.size(), 100);
    for (int i = 0; i < rx_data.size(); i++) check_eq("abort_byte", rx_data[i], frame_q[i]);
    @(posedge clk);
    #1 reset_n = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    release_reset();
    full_frame(4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
